// File: rtl/time_keeper.sv
// ---------------------------------------------------------------------------
// time_keeper
//
// Keeps the BCD time of day and the alarm setting for the alarm clock and
// turns keypad digits into new time or alarm values.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   one_minute   single-cycle pulse; advances current_time by one minute
//   key_valid    single-cycle strobe qualifying key
//   key[3:0]     0-9 digit, 4'hA clear, 4'hB-4'hF ignored
//   load_time    single-cycle strobe; commits the buffer to current_time
//   load_alarm   single-cycle strobe; commits the buffer to alarm_time
//   current_time BCD {ms_hour, ls_hour, ms_min, ls_min}
//   alarm_time   BCD, same layout
//   key_buffer   digits entered so far, newest digit in [3:0]
//   show_keypad  high while an entry is in progress
//   load_error   one-cycle pulse when a load is rejected
//
// Configuration macro: TIME_KEEPER_TIMEOUT_EN
//   defined   - an unfinished entry is abandoned after TIMEOUT_CYCLES idle
//               clocks following the last digit
//   undefined - no timeout counter; entry lasts until a clear or a load
// ---------------------------------------------------------------------------
module time_keeper #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        one_minute,
    input  logic        key_valid,
    input  logic [3:0]  key,
    input  logic        load_time,
    input  logic        load_alarm,
    output logic [15:0] current_time,
    output logic [15:0] alarm_time,
    output logic [15:0] key_buffer,
    output logic        show_keypad,
    output logic        load_error
);

    typedef enum logic {
        IDLE  = 1'b0,
        ENTRY = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] digit_cnt;

    logic is_digit;
    logic is_clear;
    logic any_load;
    logic load_ok;
    logic tick_en;
    logic timeout_hit;

    // Legal 24-hour HH:MM in BCD.
    function automatic logic valid_time(input logic [15:0] t);
        logic [3:0] mh, lh, mm, lm;
        {mh, lh, mm, lm} = t;
        valid_time = (mh <= 4'd2) && (lh <= 4'd9) && (mm <= 4'd5) &&
                     (lm <= 4'd9) && !((mh == 4'd2) && (lh > 4'd3));
    endfunction

    // One-minute BCD increment with the 23:59 -> 00:00 wrap.
    function automatic logic [15:0] next_minute(input logic [15:0] t);
        logic [3:0] mh, lh, mm, lm;
        {mh, lh, mm, lm} = t;
        if (lm != 4'd9) begin
            lm = lm + 4'd1;
        end else begin
            lm = 4'd0;
            if (mm != 4'd5) begin
                mm = mm + 4'd1;
            end else begin
                mm = 4'd0;
                if ((mh == 4'd2) && (lh == 4'd3)) begin
                    mh = 4'd0;
                    lh = 4'd0;
                end else if (lh == 4'd9) begin
                    lh = 4'd0;
                    mh = mh + 4'd1;
                end else begin
                    lh = lh + 4'd1;
                end
            end
        end
        next_minute = {mh, lh, mm, lm};
    endfunction

    always_comb begin
        is_digit = key_valid && (key <= 4'd9);
        is_clear = key_valid && (key == 4'hA);
        any_load = load_time || load_alarm;
        load_ok  = (state == ENTRY) && (digit_cnt == 3'd4) && valid_time(key_buffer);
        // An accepted time load overrides a coincident tick.
        tick_en  = one_minute && !(load_time && load_ok);
    end

`ifdef TIME_KEEPER_TIMEOUT_EN
    logic [31:0] idle_cnt;

    assign timeout_hit = (state == ENTRY) && (idle_cnt == TIMEOUT_CYCLES - 32'd1);

    // Counts clocks in ENTRY since the last digit. Ignored keys (B-F) do not
    // restart it; anything that ends the entry or shifts a digit does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= 32'd0;
        end else if ((state == ENTRY) && !any_load && !is_clear && !is_digit && !timeout_hit) begin
            idle_cnt <= idle_cnt + 32'd1;
        end else begin
            idle_cnt <= 32'd0;
        end
    end
`else
    // No counter in this build; the parameter only stays for a uniform
    // instantiation interface and folds away to a constant.
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

    // Single sequential block: entry FSM, time/alarm registers and all
    // registered outputs. Priority: load > clear > digit > timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            digit_cnt    <= 3'd0;
            current_time <= 16'h0000;
            alarm_time   <= 16'h0000;
            key_buffer   <= 16'h0000;
            show_keypad  <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            load_error <= 1'b0;

            // Timekeeping runs regardless of entry state; an accepted time
            // load below overwrites it in the same cycle.
            if (tick_en) begin
                current_time <= next_minute(current_time);
            end

            if (any_load) begin
                // The load sees the pre-shift buffer; a coincident key is lost.
                if (load_ok) begin
                    if (load_time)  current_time <= key_buffer;
                    if (load_alarm) alarm_time   <= key_buffer;
                end else begin
                    load_error <= 1'b1;
                end
                key_buffer  <= 16'h0000;
                digit_cnt   <= 3'd0;
                state       <= IDLE;
                show_keypad <= 1'b0;
            end else if (is_clear || (timeout_hit && !is_digit)) begin
                key_buffer  <= 16'h0000;
                digit_cnt   <= 3'd0;
                state       <= IDLE;
                show_keypad <= 1'b0;
            end else if (is_digit) begin
                key_buffer  <= {key_buffer[11:0], key};
                if (digit_cnt != 3'd4) begin
                    digit_cnt <= digit_cnt + 3'd1;
                end
                state       <= ENTRY;
                show_keypad <= 1'b1;
            end
        end
    end

endmodule
